uart_rx_48: RTL
===============

# uart_rx_48

UART receiver for 8N1 serial data, clocked directly from the 48 MHz `SB_HFOSC` output (`clk_48`). It oversamples the asynchronous `uart_rx` pin, finds start bits, samples each bit at mid-bit, and hands complete bytes to the fabric through a ready/valid holding register. It is the receive-side counterpart to the UART transmitter and connects to the same `resetter` output.

## Interface
- `BAUD_DIV`, default 417: `clk_48` cycles per bit (48 MHz / 115200 ≈ 416.7). Legal range 4..65535.
- `clk_48`  in  1  48 MHz clock; the only clock in the block.
- `reset`  in  1  reset, synchronous, active-high; clock clk_48.
- `uart_rx`  in  1  asynchronous serial input; idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rx_data`  out  8  last received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  holding register full.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while `rx_valid` was high; the new byte is dropped.

## Operation
- Synchronizer: 2 flops on `uart_rx` give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- Bit counter: 16-bit `cnt`, counts 0..BAUD_DIV-1. `HALF = (BAUD_DIV-1)>>1`, which is 208 at the default.
- 3-bit `bit_idx` and 8-bit shift register `sh`. Bits arrive LSB first; each sample shifts into `sh[7]` (right shift).
- IDLE: `cnt`=0. If `rx_s`==0, go to START.
- START: `cnt` increments. At `cnt`==HALF:
  - `rx_s`==1: glitch, go to IDLE.
  - otherwise clear `cnt` and `bit_idx`, then go to DATA.
- DATA: at `cnt`==BAUD_DIV-1, sample `rx_s` into `sh`, clear `cnt`, and increment `bit_idx`. After the sample taken with `bit_idx`==7, go to STOP.
- STOP: at `cnt`==BAUD_DIV-1, sample `rx_s`:
  - 1 with `rx_valid`==0: load `rx_data`←`sh`, set `rx_valid`, go to IDLE.
  - 1 with `rx_valid`==1: pulse `overrun`, leave `rx_data` unchanged, go to IDLE.
  - 0: pulse `frame_error`, discard the byte, go to WAIT_HI.
- WAIT_HI: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as 0x00 frames.
- Holding register: `rx_valid` clears on the cycle after `rx_valid && rx_ready`.
- Load and handshake in the same cycle: if a load and an accept happen together, the load wins. `rx_valid` stays 1 with the new data, and no overrun is reported.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_error`=0, `overrun`=0, state IDLE, `cnt`=0, `bit_idx`=0, `sh`=0, synchronizer flops=1.
- Reset mid-frame returns the block to IDLE on the next edge and discards the partial byte.
- Falling edge at pin → `rx_s` low: 2 cycles.
- Start sample: HALF+1 cycles after entering START.
- Each data bit and the stop bit are sampled BAUD_DIV cycles apart, so all samples fall at mid-bit.
- `rx_valid`, `frame_error` and `overrun` are registered and change on the cycle after the stop sample. Pulses are exactly 1 cycle wide.
- Back-to-back frames: returning to IDLE at mid-stop means a start edge arriving half a bit later is caught.
- Tolerated baud mismatch: about ±4% over 10 bits.
- `rx_ready` may be held high permanently. `rx_valid` then pulses for 1 cycle per byte.

## Test plan
- Reset, then drive the frame for 0x61 at 417 cycles/bit with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0x61, held stable. Assert `rx_ready` for 1 cycle → `rx_valid`=0 on the next cycle.
- Drive 0x61..0x7A back-to-back with no idle gap and `rx_ready`=1 → 26 `rx_valid` pulses with matching data, no `frame_error`, no `overrun`.
- Drive a 100-cycle low glitch on idle `uart_rx` → no state change past START and no outputs.
- Drive a frame for 0x55 with the stop bit low, then hold the line low for 3 bit times, then high → one `frame_error` pulse, `rx_valid` stays 0. A following 0xA5 is received correctly.
- Send 0x12 and 0x34 with `rx_ready`=0 → `rx_data`=0x12, and one `overrun` pulse at the 0x34 stop sample.
- Assert `reset` mid-way through the data bits of 0xFF, then send 0x3C → only 0x3C is delivered. Also repeat the 0x61 test at ±3% bit period → byte received correctly.

Source files
------------

// File: rtl/uart_rx_48.sv
// 8N1 UART receiver on the 48 MHz oscillator clock.
// Mid-bit sampling with a single-entry ready/valid holding register.
module uart_rx_48 #(
   parameter int BAUD_DIV = 417
) (
   input  logic       clk_48,
   input  logic       reset,
   input  logic       uart_rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       overrun
);

   localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF = 16'((BAUD_DIV - 1) >> 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } state_t;

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  sh_q;
   logic        sync_q;
   logic        rx_s_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        ferr_q;
   logic        ovr_q;
   logic        take;

   // A byte may load when the register is empty or is being drained now.
   assign take = !valid_q || rx_ready;

   always_ff @(posedge clk_48) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         sh_q      <= '0;
         sync_q    <= 1'b1;
         rx_s_q    <= 1'b1;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync_q <= uart_rx;
         rx_s_q <= sync_q;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         if (valid_q && rx_ready)
            valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rx_s_q)
                  state_q <= START;
            end
            START: begin
               if (cnt_q == HALF) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  state_q   <= rx_s_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (cnt_q == LAST) begin
                  sh_q      <= {rx_s_q, sh_q[7:1]};
                  cnt_q     <= '0;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7)
                     state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= IDLE;
                     if (take) begin
                        data_q  <= sh_q;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_HI;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            WAIT_HI: begin
               cnt_q <= '0;
               if (rx_s_q)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_error = ferr_q;
   assign overrun     = ovr_q;

endmodule
